// File: rtl/round_cnt_pkg.sv
// Shared definitions for the round counter: FSM state encoding and the
// default round count / index width.
package round_cnt_pkg;

    localparam int ROUNDS_DEF = 32;
    localparam int CNT_W_DEF  = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/round_counter.sv
// Round index sequencer for an iterated cipher core.
// A start in IDLE launches ROUNDS rounds, stepping the index on each adv.
// A one-cycle DONE state follows, then the block returns to IDLE.
// Build option: define ROUND_CNT_DIR_EN to honour dir (descending count for
// decrypt). Without it, dir is accepted but ignored and counting ascends.
module round_counter
    import round_cnt_pkg::*;
#(
    parameter int ROUNDS = ROUNDS_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             dir,
    input  logic             adv,
    input  logic             abort,
    output logic [CNT_W-1:0] cnt,
    output logic             round_vld,
    output logic             first,
    output logic             last,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(ROUNDS - 1);
    // A single-round operation starts on its terminal round.
    localparam logic             ONE_ROUND = (ROUNDS == 1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             dir_q;
    logic             round_vld_q;
    logic             first_q;
    logic             last_q;
    logic             busy_q;
    logic             done_q;

    logic             dir_eff;
    logic [CNT_W-1:0] term_cnt;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] start_cnt_d;

`ifdef ROUND_CNT_DIR_EN
    assign dir_eff = dir;
`else
    // Port kept for interface compatibility; the value never matters.
    assign dir_eff = 1'b0 & dir;
`endif

    // Terminal index for the latched direction, next stepped index and
    // the starting index for a newly requested operation.
    always_comb begin
        term_cnt    = dir_q ? '0 : LAST_IDX;
        cnt_d       = dir_q ? (cnt_q - CNT_W'(1)) : (cnt_q + CNT_W'(1));
        start_cnt_d = dir_eff ? LAST_IDX : '0;
    end

    // Control FSM; every output is a register updated here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            dir_q       <= 1'b0;
            round_vld_q <= 1'b0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start && !abort) begin
                        state_q     <= ST_RUN;
                        dir_q       <= dir_eff;
                        cnt_q       <= start_cnt_d;
                        round_vld_q <= 1'b1;
                        first_q     <= 1'b1;
                        last_q      <= ONE_ROUND;
                        busy_q      <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state_q     <= ST_IDLE;
                        cnt_q       <= '0;
                        round_vld_q <= 1'b0;
                        first_q     <= 1'b0;
                        last_q      <= 1'b0;
                        busy_q      <= 1'b0;
                    end else if (adv) begin
                        if (cnt_q == term_cnt) begin
                            // Index holds the terminal value through DONE.
                            state_q     <= ST_DONE;
                            round_vld_q <= 1'b0;
                            first_q     <= 1'b0;
                            last_q      <= 1'b0;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                        end else begin
                            cnt_q   <= cnt_d;
                            first_q <= 1'b0;
                            last_q  <= (cnt_d == term_cnt);
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    cnt_q       <= '0;
                    round_vld_q <= 1'b0;
                    first_q     <= 1'b0;
                    last_q      <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign cnt       = cnt_q;
    assign round_vld = round_vld_q;
    assign first     = first_q;
    assign last      = last_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_round_counter.sv
// Randomised and directed bench for round_counter. Two instances share the
// stimulus: ROUNDS=32 (CNT_W=5) and ROUNDS=1 (CNT_W=1). A round-number
// model predicts every output after each clock edge.
module tb_round_counter;

    localparam int R0 = 32;
    localparam int R1 = 1;

`ifdef ROUND_CNT_DIR_EN
    localparam bit DIR_EN = 1'b1;
`else
    localparam bit DIR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic dir = 1'b0;
    logic adv = 1'b0;
    logic abort = 1'b0;

    logic [4:0] cnt0;
    logic       vld0, first0, last0, busy0, done0;
    logic [0:0] cnt1;
    logic       vld1, first1, last1, busy1, done1;

    round_counter #(.ROUNDS(R0), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .start(start), .dir(dir), .adv(adv), .abort(abort),
        .cnt(cnt0), .round_vld(vld0), .first(first0), .last(last0),
        .busy(busy0), .done(done0)
    );

    round_counter #(.ROUNDS(R1), .CNT_W(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .dir(dir), .adv(adv), .abort(abort),
        .cnt(cnt1), .round_vld(vld1), .first(first1), .last(last1),
        .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Model: phase 0=idle 1=running 2=completing; k = rounds already stepped.
    int m_ph[2];
    int m_k[2];
    bit m_d[2];
    int m_r[2] = '{R0, R1};

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_ph[i] = 0;
            m_k[i]  = 0;
            m_d[i]  = 1'b0;
        end
    endfunction

    function automatic void model_step();
        for (int i = 0; i < 2; i++) begin
            case (m_ph[i])
                0: if (start && !abort) begin
                    m_ph[i] = 1;
                    m_k[i]  = 0;
                    m_d[i]  = DIR_EN & dir;
                end
                1: if (abort) m_ph[i] = 0;
                   else if (adv) begin
                       if (m_k[i] == m_r[i] - 1) m_ph[i] = 2;
                       else m_k[i] = m_k[i] + 1;
                   end
                default: m_ph[i] = 0;
            endcase
        end
    endfunction

    function automatic int exp_cnt(int i);
        case (m_ph[i])
            1:       return m_d[i] ? (m_r[i] - 1 - m_k[i]) : m_k[i];
            2:       return m_d[i] ? 0 : (m_r[i] - 1);
            default: return 0;
        endcase
    endfunction

    task automatic check_outs();
        bit run0, run1;
        run0 = (m_ph[0] == 1);
        run1 = (m_ph[1] == 1);
        chk("cnt32",   32'(cnt0),   exp_cnt(0));
        chk("vld32",   32'(vld0),   32'(run0));
        chk("first32", 32'(first0), 32'(run0 && m_k[0] == 0));
        chk("last32",  32'(last0),  32'(run0 && m_k[0] == R0 - 1));
        chk("busy32",  32'(busy0),  32'(run0));
        chk("done32",  32'(done0),  32'(m_ph[0] == 2));
        chk("cnt1",    32'(cnt1),   exp_cnt(1));
        chk("vld1",    32'(vld1),   32'(run1));
        chk("first1",  32'(first1), 32'(run1 && m_k[1] == 0));
        chk("last1",   32'(last1),  32'(run1 && m_k[1] == R1 - 1));
        chk("busy1",   32'(busy1),  32'(run1));
        chk("done1",   32'(done1),  32'(m_ph[1] == 2));
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        #1;
        check_outs();
    endtask

    // One operation on the 32-round instance; returns cycles from the start
    // sample to done (-1 if none). Triggers at -1 are disabled.
    task automatic run_op(input bit d, input int stall_at, input int abort_at,
                          input int pulse_at, output int lat);
        int c;
        int stalled;
        stalled = 0;
        lat = -1;
        dir = d; adv = 1'b1; abort = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        dir = ~d;                 // direction must stay latched
        c = 1;
        while (c < 120) begin
            if (done0 === 1'b1) begin
                lat = c;
                break;
            end
            if (busy0 !== 1'b1) break;
            adv = 1'b1; abort = 1'b0; start = 1'b0;
            if (32'(cnt0) == stall_at && stalled < 3) begin
                adv = 1'b0;
                stalled++;
            end else if (32'(cnt0) == pulse_at) begin
                start = 1'b1;
            end
            if (32'(cnt0) == abort_at) abort = 1'b1;
            step();
            c++;
        end
        if (c >= 120) chk("op_timeout", 32'(c), 32'(0));
        adv = 1'b1; abort = 1'b0; start = 1'b0;
        step();
        step();
        $display("op dir=%0d stall=%0d abort=%0d pulse=%0d latency=%0d",
                 d, stall_at, abort_at, pulse_at, lat);
    endtask

    int lat;
    int n;

    initial begin
        model_reset();
        #1 rst = 1'b1;
        #1;
        check_outs();
        step();
        step();
        rst = 1'b0;
        step();

        // Plain ascending run.
        run_op(1'b0, -1, -1, -1, lat);
        chk("lat_asc", lat, 33);
        chk("idle_cnt", 32'(cnt0), 0);

        // Stall three cycles at index 7.
        run_op(1'b0, 7, -1, -1, lat);
        chk("lat_stall", lat, 36);

        // Descending request (ascending unless direction feature is built).
        run_op(1'b1, -1, -1, -1, lat);
        chk("lat_desc", lat, 33);

        // Abort at index 10: no done pulse, back to idle.
        run_op(1'b0, -1, 10, -1, lat);
        chk("abort_nodone", lat, -1);
        chk("abort_busy", 32'(busy0), 0);

        // Start pulse mid-run is ignored.
        run_op(1'b0, -1, -1, 5, lat);
        chk("lat_pulse", lat, 33);

        // Start together with abort in idle stays idle.
        start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        chk("start_abort_idle", 32'(busy0), 0);
        $display("op start+abort in idle busy=%0d", busy0);

        // Single-round instance: one live round, then done.
        adv = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        chk("r1_round", 32'({vld1, first1, last1}), 32'(3'b111));
        step();
        chk("r1_done", 32'(done1), 1);
        n = 0;
        while (busy0 === 1'b1 && n < 100) begin
            step();
            n++;
        end
        step();
        step();
        $display("op single-round done observed");

        // Asynchronous reset mid-operation at index 20.
        dir = 1'b0; adv = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (cnt0 != 5'd20 && n < 100) begin
            step();
            n++;
        end
        #3 rst = 1'b1;
        #1;
        model_reset();
        check_outs();
        chk("rst_async_busy", 32'(busy0), 0);
        step();
        rst = 1'b0;
        step();
        $display("op async reset at cnt=20");
        run_op(1'b0, -1, -1, -1, lat);
        chk("lat_after_rst", lat, 33);

        // Randomised traffic.
        for (int i = 0; i < 1500; i++) begin
            start = ($urandom_range(0, 3) == 0);
            dir   = $urandom_range(0, 1);
            adv   = ($urandom_range(0, 3) != 0);
            abort = ($urandom_range(0, 63) == 0);
            rst   = ($urandom_range(0, 199) == 0);
            step();
            if (done0 === 1'b1) $display("op random done at iter %0d cnt=%0d", i, cnt0);
        end
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/round_counter.md
ROUND_COUNTER -- requirements
Module: round_counter

Interface
REQ-001 The block SHALL use a single clock clk, and reset rst SHALL be asynchronous and active-high.
REQ-002 Parameter ROUNDS, default 32, SHALL set the number of rounds per operation; legal range is 1..2**CNT_W.
REQ-003 Parameter CNT_W, default 5, SHALL set the width of the round index.
REQ-004 Port clk, input, 1, SHALL be the rising-edge clock.
REQ-005 Port rst, input, 1, SHALL be the asynchronous active-high reset.
REQ-006 Port start, input, 1, SHALL request a new operation; it is sampled only in IDLE.
REQ-007 Port dir, input, 1, SHALL select count direction: 0 = ascending (encrypt), 1 = descending (decrypt); it is sampled with start.
REQ-008 Port adv, input, 1, SHALL allow the round index to advance; 0 stalls the index.
REQ-009 Port abort, input, 1, SHALL cancel the operation synchronously.
REQ-010 Port cnt, output, CNT_W, SHALL carry the current round index.
REQ-011 Port round_vld, output, 1, SHALL be high while cnt names a live round.
REQ-012 Port first, output, 1, SHALL be high on the first round of an operation.
REQ-013 Port last, output, 1, SHALL be high on the terminal round of an operation.
REQ-014 Port busy, output, 1, SHALL be high in RUN.
REQ-015 Port done, output, 1, SHALL pulse for one cycle when an operation completes.

Function
REQ-016 The FSM SHALL have three states, IDLE, RUN and DONE, and all outputs SHALL be registered.
REQ-017 In IDLE, start=1 with abort=0 SHALL cause the next cycle to be RUN, with cnt = 0 (dir=0) or ROUNDS-1 (dir=1), round_vld=1 and first=1.
REQ-018 In RUN, adv=1 with cnt not terminal SHALL step cnt by +1 (ascending) or -1 (descending); first SHALL then be 0.
REQ-019 In RUN, adv=0 SHALL hold cnt, first and last unchanged; round_vld SHALL stay 1.
REQ-020 The terminal value SHALL be ROUNDS-1 when ascending and 0 when descending; last SHALL equal (cnt == terminal) while in RUN.
REQ-021 In RUN, adv=1 with cnt at terminal SHALL move the FSM to DONE; in DONE, done=1, round_vld=0, busy=0, and cnt SHALL hold the terminal value.
REQ-022 DONE SHALL last exactly one cycle, after which the FSM returns to IDLE with cnt=0.
REQ-023 With continuous adv, done SHALL assert ROUNDS+1 cycles after the cycle in which start is sampled.
REQ-024 start in RUN or DONE SHALL be ignored; no re-trigger and no queuing.
REQ-025 abort in RUN or DONE SHALL return the FSM to IDLE the next cycle with cnt=0 and no done pulse; abort SHALL have priority over adv and start.
REQ-026 When ROUNDS=1, first and last SHALL both be 1 on the single round.
REQ-027 cnt SHALL never leave the range 0..ROUNDS-1; it SHALL not wrap.
REQ-028 The latched direction SHALL stay fixed for the whole operation regardless of dir changes.

Reset
REQ-029 Asserting rst SHALL force, immediately and regardless of state: state=IDLE, cnt=0, round_vld=0, first=0, last=0, busy=0, done=0, latched dir=0.
REQ-030 Reset asserted mid-operation SHALL discard the operation with no done pulse; the first start after rst release SHALL begin a fresh operation.

Configuration
REQ-031 With macro ROUND_CNT_DIR_EN defined, dir SHALL behave as in REQ-007.
REQ-032 Without ROUND_CNT_DIR_EN, the dir port SHALL remain present but be ignored, and counting SHALL always be ascending.

Structure
REQ-033 Package round_cnt_pkg SHALL hold the FSM state enum typedef and the default constants ROUNDS_DEF=32 and CNT_W_DEF=5.
REQ-034 The block SHALL be a single module; no sub-module is required.

Verification
REQ-035 Bench SHALL cover: ROUNDS=32, dir=0, adv=1, start pulse -> round_vld high 32 cycles with cnt 0..31, first only at 0, last only at 31, done 1 cycle at the 33rd cycle after the start sample, then cnt=0.
REQ-036 Bench SHALL cover: adv=0 for 3 cycles while cnt=7 -> cnt holds 7 for those cycles and done asserts 3 cycles later than in REQ-035.
REQ-037 Bench SHALL cover: ROUND_CNT_DIR_EN defined, dir=1 -> cnt 31..0, first at 31, last at 0; without the macro the same stimulus -> cnt 0..31.
REQ-038 Bench SHALL cover: abort at cnt=10 -> next cycle IDLE, cnt=0, busy=0, no done; start asserted together with abort in IDLE -> remains IDLE.
REQ-039 Bench SHALL cover: rst asserted asynchronously at cnt=20 -> all outputs 0 before the next clk edge; start pulse during RUN at cnt=5 -> no effect on cnt.
REQ-040 Bench SHALL cover: ROUNDS=1 -> one cycle with round_vld=first=last=1 and cnt=0, then done the following cycle.
